// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: owns the working variables a..h, the 16-word message window and
// the round counter, and drives an external combinational round unit once per clock.
module sha256_round_ctrl #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] block_in,
  input  logic [255:0] h_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest,
  output logic [255:0] rnd_state,
  output logic [31:0]  rnd_w,
  output logic [5:0]   rnd_select,
  input  logic [31:0]  rnd_new_a,
  input  logic [31:0]  rnd_new_e
);

  typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

  localparam logic [5:0] LastT = 6'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [255:0]      hs_q, hs_d;
  logic [255:0]      st_q, st_d;
  logic [255:0]      digest_q, digest_d;
  logic [15:0][31:0] w_q, w_d;
  logic [5:0]        t_q, t_d;
  logic              done_q, done_d;
  logic [31:0]       w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w_next = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  always_comb begin
    state_d  = state_q;
    hs_d     = hs_q;
    st_d     = st_q;
    digest_d = digest_q;
    w_d      = w_q;
    t_d      = t_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StRound;
          hs_d    = h_in;
          st_d    = h_in;
          t_d     = 6'd0;
          // Message word 0 sits in the top bits of block_in but at index 0 of the window.
          for (int i = 0; i < 16; i++) begin
            w_d[i] = block_in[32*(15-i) +: 32];
          end
        end
      end
      StRound: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          st_d = {rnd_new_a, st_q[255:224], st_q[223:192], st_q[191:160],
                  rnd_new_e, st_q[127:96],  st_q[95:64],   st_q[63:32]};
          w_d  = {w_next, w_q[15:1]};
          t_d  = t_q + 6'd1;
          if (t_q == LastT) begin
            state_d = StFinal;
          end
        end
      end
      StFinal: begin
        state_d = StIdle;
        if (!abort) begin
          done_d = 1'b1;
          for (int i = 0; i < 8; i++) begin
            digest_d[32*i +: 32] = hs_q[32*i +: 32] + st_q[32*i +: 32];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hs_q     <= '0;
      st_q     <= '0;
      digest_q <= '0;
      w_q      <= '0;
      t_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_q     <= hs_d;
      st_q     <= st_d;
      digest_q <= digest_d;
      w_q      <= w_d;
      t_q      <= t_d;
      done_q   <= done_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign digest     = digest_q;
  assign rnd_state  = st_q;
  assign rnd_w      = w_q[0];
  assign rnd_select = (state_q == StRound) ? t_q : 6'd0;

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 64: number of compression rounds per block; legal range 1..64; 64 in production, smaller values for bench only.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: begin compressing block_in with h_in.
REQ-005 SHALL have port abort, input, 1 bit: cancel the block in progress.
REQ-006 SHALL have port block_in, input, 512 bits: message block; word 0 = [511:480].
REQ-007 SHALL have port h_in, input, 256 bits: chaining value; H0 = [255:224].
REQ-008 SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when digest is valid.
REQ-010 SHALL have port digest, output, 256 bits: result; H0 = [255:224].
REQ-011 SHALL have port rnd_state, output, 256 bits: {a,b,c,d,e,f,g,h} to the round unit, a = [255:224].
REQ-012 SHALL have port rnd_w, output, 32 bits: schedule word W[t] to the round unit.
REQ-013 SHALL have port rnd_select, output, 6 bits: round index t to the round unit, which uses it for the K lookup.
REQ-014 SHALL have port rnd_new_a, input, 32 bits: round-unit result for the next a.
REQ-015 SHALL have port rnd_new_e, input, 32 bits: round-unit result for the next e.

Function
REQ-016 SHALL implement FSM states IDLE, ROUND and FINAL.
REQ-017 Transition IDLE->ROUND SHALL occur on a clock edge with start=1 and abort=0; at that edge the block SHALL latch h_in into a latched copy Hs, load a..h from h_in, load the 16-word window w[0..15] from block_in, and set t=0.
REQ-018 In ROUND, each edge SHALL perform a=rnd_new_a, b=a, c=b, d=c, e=rnd_new_e, f=e, g=f, h=g.
REQ-019 In ROUND, each edge SHALL shift the window: w[i]=w[i+1] for i=0..14, and w[15] = s1(w[14]) + w[9] + s0(w[1]) + w[0], all addition mod 2^32.
REQ-020 The s-functions SHALL be: s0(x)=ror7^ror18^shr3; s1(x)=ror17^ror19^shr10.
REQ-021 In ROUND, rnd_w SHALL equal w[0], rnd_select SHALL equal t, and rnd_state SHALL equal the current a..h, all combinationally from registers; the round unit is combinational, so results are consumed the same cycle.
REQ-022 In ROUND, t SHALL increment each edge; on the edge where t=ROUNDS-1 the FSM SHALL go to FINAL.
REQ-023 At the FINAL edge, digest SHALL be set to Hs[i]+{a..h}[i] per 32-bit word (mod 2^32), done=1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-024 Latency: with start sampled at edge N, the rounds SHALL occupy edges N+1..N+ROUNDS and done SHALL be high in the cycle after edge N+ROUNDS+1.
REQ-025 digest SHALL hold its value until the next FINAL or reset.
REQ-026 Outside ROUND, rnd_select SHALL be 0.
REQ-027 start SHALL be ignored while busy=1; a new start SHALL be accepted in the same cycle done is high, because the FSM is already IDLE.
REQ-028 abort=1 in ROUND or FINAL SHALL return the FSM to IDLE at the next edge with no done pulse and digest unchanged.
REQ-029 abort SHALL take priority over start and over the FINAL update.
REQ-030 busy SHALL be 1 in ROUND and FINAL and 0 in IDLE.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, without a clock, set the FSM to IDLE and clear busy, done, digest, a..h, Hs, the window, t and rnd_select to 0.
REQ-032 Reset asserted mid-block SHALL discard the block; no done SHALL follow the release of rst_n.
REQ-033 Operation SHALL resume only on a new start after rst_n=1.

Verification
REQ-034 Test "abc": block_in=61626380_0..0_00000018, h_in = SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), connected to a golden round unit -> done exactly 65 cycles after start, digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-035 Start held high for 200 cycles -> exactly one done per 66-cycle interval (start re-accepted in the done cycle), rnd_select sweeping 0..63 each block.
REQ-036 Abort at t=30 -> busy low next cycle, no done, digest keeps the previous value; a subsequent "abc" start -> correct digest.
REQ-037 rst_n pulsed low at t=40 -> all outputs 0 immediately, no done within 100 cycles after release.
REQ-038 Window check with block words 0..15 = 1..16 -> rnd_w = 1..16 for t=0..15, and rnd_w at t=16 equals s1(15)+10+s0(2)+1.
REQ-039 ROUNDS=2 build -> done 3 cycles after start, digest = h_in + state after two rounds.
